// File: rtl/matrix_stack_if.sv
// matrix_stack_if: command, row-data and peek bundle between the geometry front end and matrix_stack_ctrl
interface matrix_stack_if #(
    parameter int ELEM_W     = 32,
    parameter int ROWS       = 4,
    parameter int DEPTH      = 8,
    parameter int NUM_STACKS = 2
);
    localparam int ROW_W = ROWS * ELEM_W;
    localparam int MAT_W = ROWS * ROW_W;
    localparam int LVL_W = $clog2(DEPTH);
    localparam int SEL_W = NUM_STACKS > 1 ? $clog2(NUM_STACKS) : 1;
    logic [SEL_W-1:0] mode;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [ROW_W-1:0] data_in;
    logic             data_valid;
    logic [MAT_W-1:0] write_in;
    logic [MAT_W-1:0] peek_out;
    logic [LVL_W:0]   depth_out;
    logic             op_done;
    logic             err_overflow;
    logic             err_underflow;
    modport master (
        output mode, cmd_valid, cmd_op, data_in, data_valid, write_in,
        input  cmd_ready, peek_out, depth_out, op_done, err_overflow, err_underflow
    );
    modport slave (
        input  mode, cmd_valid, cmd_op, data_in, data_valid, write_in,
        output cmd_ready, peek_out, depth_out, op_done, err_overflow, err_underflow
    );
endinterface

// File: rtl/matrix_stack_ctrl.sv
// matrix_stack_ctrl: NUM_STACKS independent GL-style matrix stacks with push/pop/load/write and a combinational top peek
module matrix_stack_ctrl #(
    parameter int                ELEM_W     = 32,
    parameter int                ROWS       = 4,
    parameter int                DEPTH      = 8,
    parameter int                NUM_STACKS = 2,
    parameter logic [ELEM_W-1:0] ONE        = 32'h3F800000
) (
    input logic           clk,
    input logic           rst_n,
    matrix_stack_if.slave bus
);
    localparam int ROW_W = ROWS * ELEM_W;
    localparam int MAT_W = ROWS * ROW_W;
    localparam int LVL_W = $clog2(DEPTH);
    localparam int SEL_W = NUM_STACKS > 1 ? $clog2(NUM_STACKS) : 1;
    localparam int CNT_W = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam logic [2:0] OP_LOAD_ID = 3'd1, OP_LOAD = 3'd2, OP_PUSH = 3'd3, OP_POP = 3'd4, OP_WRITE = 3'd5;

    typedef enum logic {S_IDLE, S_LOAD} state_t;
    state_t state, state_nxt;

    logic [MAT_W-1:0] mem [NUM_STACKS][DEPTH];
    logic [LVL_W-1:0] level [NUM_STACKS];
    logic [ROW_W-1:0] shadow [ROWS];
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel, rsel;
    logic [LVL_W-1:0] lvl;
    logic [MAT_W-1:0] ident, load_mat, top;
    logic mode_ok, ready, cmd_go, commit, last_row, done, ovf, unf;

    always_comb begin
        ident = '0;
        for (int r = 0; r < ROWS; r++)
            ident[MAT_W-1-r*ROW_W-r*ELEM_W -: ELEM_W] = ONE;
    end

    // Out-of-range modes read stack 0 and have their commands dropped
    assign mode_ok  = {1'b0, bus.mode} < (SEL_W+1)'(NUM_STACKS);
    assign rsel     = mode_ok ? bus.mode : '0;
    assign lvl      = level[rsel];
    assign top      = mem[rsel][lvl];
    assign cmd_go   = bus.cmd_valid && ready && mode_ok;
    assign last_row = cnt == CNT_W'(ROWS - 1);
    assign commit   = state == S_LOAD && bus.data_valid && last_row;

    // Last row comes straight from data_in so the commit lands on the capturing edge
    always_comb begin
        load_mat = '0;
        for (int r = 0; r < ROWS; r++)
            load_mat[MAT_W-1-r*ROW_W -: ROW_W] = r == ROWS - 1 ? bus.data_in : shadow[r];
    end

    always_ff @(posedge clk)
        state <= !rst_n ? S_IDLE : state_nxt;

    always_comb
        state_nxt = state == S_IDLE ? (cmd_go && bus.cmd_op == OP_LOAD ? S_LOAD : S_IDLE)
                                    : (commit ? S_IDLE : S_LOAD);

    always_comb
        ready = state == S_IDLE;

    always_ff @(posedge clk)
        if (state == S_LOAD && bus.data_valid)
            shadow[cnt] <= bus.data_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STACKS; s++) begin
                level[s] <= '0;
                for (int d = 0; d < DEPTH; d++)
                    mem[s][d] <= d == 0 ? ident : '0;
            end
            done <= 1'b0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
            cnt  <= '0;
            sel  <= '0;
        end else begin
            done <= commit;
            ovf  <= 1'b0;
            unf  <= 1'b0;
            if (state == S_LOAD && bus.data_valid)
                cnt <= cnt + 1'b1;
            if (commit)
                mem[sel][level[sel]] <= load_mat;
            if (cmd_go)
                case (bus.cmd_op)
                    OP_LOAD_ID: begin
                        mem[rsel][lvl] <= ident;
                        done <= 1'b1;
                    end
                    OP_WRITE: begin
                        mem[rsel][lvl] <= bus.write_in;
                        done <= 1'b1;
                    end
                    OP_PUSH:
                        if (lvl != LVL_W'(DEPTH - 1)) begin
                            mem[rsel][lvl + 1'b1] <= top;
                            level[rsel] <= lvl + 1'b1;
                            done <= 1'b1;
                        end else
                            ovf <= 1'b1;
                    OP_POP:
                        if (lvl != '0) begin
                            level[rsel] <= lvl - 1'b1;
                            done <= 1'b1;
                        end else
                            unf <= 1'b1;
                    OP_LOAD: begin
                        sel <= rsel;
                        cnt <= '0;
                    end
                    default: ;
                endcase
        end
    end

    assign bus.cmd_ready     = ready;
    assign bus.peek_out      = top;
    assign bus.depth_out     = {1'b0, lvl} + 1'b1;
    assign bus.op_done       = done;
    assign bus.err_overflow  = ovf;
    assign bus.err_underflow = unf;
endmodule

// File: tb/tb_matrix_stack_ctrl.sv
// tb_matrix_stack_ctrl: directed stimulus checked every cycle against a queue-based stack model
module tb_matrix_stack_ctrl;
    localparam int ROWS = 4, DEPTH = 8, ROW_W = 128, MAT_W = 512;
    localparam logic [2:0] LOAD_ID = 3'd1, LOAD = 3'd2, PUSH = 3'd3, POP = 3'd4, WRITE = 3'd5;
    localparam logic [MAT_W-1:0] IDENT =
        512'h3F800000_00000000_00000000_00000000_00000000_3F800000_00000000_00000000_00000000_00000000_3F800000_00000000_00000000_00000000_00000000_3F800000;
    typedef logic [MAT_W-1:0] mat_t;

    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, errors = 0;

    matrix_stack_if #(.ELEM_W(32), .ROWS(ROWS), .DEPTH(DEPTH), .NUM_STACKS(2)) bus();
    matrix_stack_ctrl #(.ELEM_W(32), .ROWS(ROWS), .DEPTH(DEPTH), .NUM_STACKS(2), .ONE(32'h3F800000))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    mat_t stk [2][$];
    logic [ROW_W-1:0] rows [$];
    bit loading = 0, armed = 0, e_done = 0, e_ovf = 0, e_unf = 0;
    int lsel = 0;

    task automatic chk(input string nm, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Stack model: each stack is a queue whose back is the top matrix
    task automatic model_step();
        e_done = 0; e_ovf = 0; e_unf = 0;
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                stk[s].delete();
                stk[s].push_back(IDENT);
            end
            loading = 0;
            armed = 1;
        end else if (loading) begin
            if (bus.data_valid) begin
                rows.push_back(bus.data_in);
                if (rows.size() == ROWS) begin
                    mat_t m;
                    m = '0;
                    foreach (rows[i]) m = {m[MAT_W-ROW_W-1:0], rows[i]};
                    stk[lsel][stk[lsel].size()-1] = m;
                    loading = 0;
                    e_done = 1;
                end
            end
        end else if (bus.cmd_valid) begin
            int s, n;
            s = int'(bus.mode);
            n = stk[s].size();
            case (bus.cmd_op)
                LOAD_ID: begin stk[s][n-1] = IDENT; e_done = 1; end
                WRITE:   begin stk[s][n-1] = bus.write_in; e_done = 1; end
                PUSH:    if (n < DEPTH) begin stk[s].push_back(stk[s][n-1]); e_done = 1; end else e_ovf = 1;
                POP:     if (n > 1) begin void'(stk[s].pop_back()); e_done = 1; end else e_unf = 1;
                LOAD:    begin loading = 1; lsel = s; rows.delete(); end
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        if (armed) begin
            int s;
            s = int'(bus.mode);
            chk("peek", bus.peek_out, stk[s][stk[s].size()-1]);
            chk("depth", bus.depth_out, stk[s].size());
            chk("ready", bus.cmd_ready, !loading);
            chk("op_done", bus.op_done, e_done);
            chk("err_overflow", bus.err_overflow, e_ovf);
            chk("err_underflow", bus.err_underflow, e_unf);
        end
    end

    task automatic issue(input logic [2:0] op, input logic m, input mat_t w);
        @(negedge clk);
        bus.mode = m; bus.cmd_op = op; bus.write_in = w; bus.cmd_valid = 1;
        @(negedge clk);
        bus.cmd_valid = 0;
        #1;
    endtask

    task automatic load(input logic m, input mat_t mat, input int gs, input bit flip, input mat_t old);
        issue(LOAD, m, '0);
        bus.cmd_valid = 1; bus.cmd_op = PUSH;
        for (int i = 0; i < ROWS; i++) begin
            for (int k = 0; k < i * gs; k++) begin
                @(negedge clk);
                bus.data_valid = 0;
                #1;
                chk("ready_gap", bus.cmd_ready, 0);
            end
            @(negedge clk);
            bus.data_valid = 1;
            bus.data_in = mat[MAT_W-1-i*ROW_W -: ROW_W];
            if (flip && i == 2) bus.mode = ~m;
            if (i == ROWS - 1) bus.cmd_valid = 0;
            #1;
            chk("ready_row", bus.cmd_ready, 0);
            if (!flip) chk("peek_old", bus.peek_out, old);
        end
        @(negedge clk);
        bus.data_valid = 0; bus.mode = m;
        #1;
        chk("peek_loaded", bus.peek_out, mat);
        chk("load_done", bus.op_done, 1);
    endtask

    initial begin
        logic [ROW_W-1:0] rv [8];
        mat_t m_w, abcd, efgh;
        bus.cmd_valid = 0; bus.data_valid = 0; bus.cmd_op = 0; bus.mode = 0;
        bus.data_in = '0; bus.write_in = '0;
        for (int i = 0; i < 8; i++) rv[i] = {32'(i + 1), 32'h3F800000, 32'(i * 3), 32'hC0000000};
        m_w  = {4{128'h40000000_3F000000_BF800000_41200000}};
        abcd = {rv[0], rv[1], rv[2], rv[3]};
        efgh = {rv[4], rv[5], rv[6], rv[7]};
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        chk("reset_peek0", bus.peek_out, IDENT);
        chk("reset_depth0", bus.depth_out, 1);
        chk("reset_ready", bus.cmd_ready, 1);
        bus.mode = 1;
        #1;
        chk("reset_peek1", bus.peek_out, IDENT);
        chk("reset_depth1", bus.depth_out, 1);

        issue(WRITE, 0, m_w);
        chk("write_peek", bus.peek_out, m_w);
        chk("write_done", bus.op_done, 1);
        issue(PUSH, 0, '0);
        chk("push_depth", bus.depth_out, 2);
        chk("push_peek", bus.peek_out, m_w);
        issue(LOAD_ID, 0, '0);
        chk("loadid_peek", bus.peek_out, IDENT);
        issue(POP, 0, '0);
        chk("pop_depth", bus.depth_out, 1);
        chk("pop_peek", bus.peek_out, m_w);
        issue(3'd6, 0, '0);
        chk("nop_done", bus.op_done, 0);

        for (int i = 0; i < DEPTH - 1; i++) issue(PUSH, 0, '0);
        chk("full_depth", bus.depth_out, DEPTH);
        issue(PUSH, 0, '0);
        chk("ovf_pulse", bus.err_overflow, 1);
        chk("ovf_depth", bus.depth_out, DEPTH);
        chk("ovf_peek", bus.peek_out, m_w);
        @(negedge clk);
        #1;
        chk("ovf_clear", bus.err_overflow, 0);
        for (int i = 0; i < DEPTH - 1; i++) issue(POP, 0, '0);
        chk("unwound_depth", bus.depth_out, 1);
        issue(POP, 1, '0);
        chk("unf_pulse", bus.err_underflow, 1);
        chk("unf_depth", bus.depth_out, 1);
        chk("unf_peek", bus.peek_out, IDENT);

        @(negedge clk);
        bus.mode = 0; bus.data_valid = 1; bus.data_in = rv[7];
        @(negedge clk);
        bus.data_valid = 0;
        #1;
        chk("idle_data_ignored", bus.peek_out, m_w);
        load(0, abcd, 1, 0, m_w);
        chk("load_depth", bus.depth_out, 1);

        load(1, efgh, 0, 1, IDENT);
        bus.mode = 0;
        #1;
        chk("other_stack_intact", bus.peek_out, abcd);

        issue(LOAD, 0, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.data_valid = 1; bus.data_in = rv[i + 4];
        end
        @(negedge clk);
        bus.data_valid = 0; rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_peek0", bus.peek_out, IDENT);
        chk("rst_depth0", bus.depth_out, 1);
        bus.mode = 1;
        #1;
        chk("rst_peek1", bus.peek_out, IDENT);
        issue(WRITE, 1, m_w);
        chk("post_rst_write", bus.peek_out, m_w);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
